// File: rtl/fifo_rd_ctrl_if.sv
// Consumer-side handshake of the FIFO read controller.
// Handshake: an entry moves when dout_valid && dout_ready are both high at a
// rising edge. Once dout_valid is high, dout and dout_valid hold until that
// transfer happens (or a flush/reset discards the entry). dout_valid never
// waits on dout_ready, and dout_ready may depend combinationally on dout_valid.
interface fifo_rd_ctrl_if #(
    parameter int WIDTH = 38
);
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             dout_ready;

    modport master (output dout, output dout_valid, input dout_ready);
    modport slave  (input dout, input dout_valid, output dout_ready);
endinterface

// File: rtl/fifo_rd_ctrl.sv
// Read-side controller for a dual-port-memory FIFO. It issues memory reads
// whenever data is available and the two-entry output buffer (head + skid)
// has room for it, so the consumer sees one entry per cycle while ready.
// Optional feature: define FIFO_RD_ALMOST_EMPTY_EN to drive almost_empty
// from total occupancy; otherwise almost_empty is tied low.
module fifo_rd_ctrl #(
    parameter int WIDTH     = 38,
    parameter int DEPTH     = 1024,
    parameter int ADDR      = 10,
    parameter int AE_THRESH = 4
) (
    input  logic                rd_clk,
    input  logic                rst_n,
    input  logic [ADDR:0]       wr_ptr,
    input  logic                flush,
    output logic                mem_rd_en,
    output logic [ADDR-1:0]     mem_rd_addr,
    input  logic [WIDTH-1:0]    mem_rd_data,
    fifo_rd_ctrl_if.master      out_if,
    output logic [ADDR:0]       rd_ptr,
    output logic                empty,
    output logic                almost_empty
);

    logic [ADDR:0]      rd_ptr_q;
    logic [ADDR:0]      rd_ptr_nxt;
    logic [ADDR:0]      mem_cnt;
    logic [1:0]         out_cnt;
    logic [1:0]         remain;
    logic [1:0]         out_cnt_nxt;
    logic [2:0]         room_used;
    logic               inflight;
    logic               pop;
    logic [WIDTH-1:0]   dout_q;
    logic [WIDTH-1:0]   skid_q;
    logic               dout_valid_q;

    // Entries still in memory; the wrap bit makes equal pointers mean empty.
    assign mem_cnt = wr_ptr - rd_ptr_q;

    // A pop during flush is ignored, so it cannot free buffer room either.
    assign pop = dout_valid_q && out_if.dout_ready && !flush;

    // Buffer slots committed after this cycle: held + arriving - leaving.
    assign room_used = {1'b0, out_cnt} + {2'b00, inflight} - {2'b00, pop};

    // rst_n gates the read so no read can leave while reset is held.
    assign mem_rd_en   = rst_n && !flush && (mem_cnt != '0) && (room_used < 3'd2);
    assign mem_rd_addr = rd_ptr_q[ADDR-1:0];

    // Slots left after a pop; an arriving entry lands in the first free one.
    assign remain      = out_cnt - {1'b0, pop};
    assign out_cnt_nxt = remain + {1'b0, inflight};

    // Pointer advance: wrap the address at the last location, flip wrap bit.
    assign rd_ptr_nxt = (rd_ptr_q[ADDR-1:0] == ADDR'(DEPTH - 1)) ?
                        {~rd_ptr_q[ADDR], {ADDR{1'b0}}} :
                        rd_ptr_q + (ADDR + 1)'(1);

    // Read pointer, in-flight tracking and the head/skid output buffer.
    always_ff @(posedge rd_clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_q     <= '0;
            out_cnt      <= 2'd0;
            inflight     <= 1'b0;
            dout_q       <= '0;
            skid_q       <= '0;
            dout_valid_q <= 1'b0;
        end else if (flush) begin
            // Resynchronise to the writer and drop everything buffered or in flight.
            rd_ptr_q     <= wr_ptr;
            out_cnt      <= 2'd0;
            inflight     <= 1'b0;
            dout_valid_q <= 1'b0;
        end else begin
            if (mem_rd_en) begin
                rd_ptr_q <= rd_ptr_nxt;
            end
            inflight     <= mem_rd_en;
            out_cnt      <= out_cnt_nxt;
            dout_valid_q <= (out_cnt_nxt != 2'd0);
            if (pop && (out_cnt == 2'd2)) begin
                dout_q <= skid_q;
            end
            if (inflight) begin
                if (remain == 2'd0) begin
                    dout_q <= mem_rd_data;
                end else begin
                    skid_q <= mem_rd_data;
                end
            end
        end
    end

    assign out_if.dout       = dout_q;
    assign out_if.dout_valid = dout_valid_q;
    assign rd_ptr            = rd_ptr_q;

    assign empty = (mem_cnt == '0) && !inflight && (out_cnt == 2'd0);

`ifdef FIFO_RD_ALMOST_EMPTY_EN
    logic [ADDR+1:0] occupancy;
    assign occupancy    = {1'b0, mem_cnt} + (ADDR + 2)'(inflight) + (ADDR + 2)'(out_cnt);
    assign almost_empty = (occupancy <= (ADDR + 2)'(AE_THRESH));
`else
    assign almost_empty = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Bench for fifo_rd_ctrl: behavioural dual-port memory, scoreboard of written
// entries checked against every pop, plus directed scenarios (latency,
// backpressure, wrap, flush, almost-empty, mid-stream reset).
module tb_fifo_rd_ctrl;

    localparam int WIDTH = 38;
    localparam int DEPTH = 1024;
    localparam int ADDR  = 10;
`ifdef FIFO_RD_ALMOST_EMPTY_EN
    localparam bit AE_ON = 1'b1;
`else
    localparam bit AE_ON = 1'b0;
`endif

    logic               rd_clk;
    logic               rst_n;
    logic [ADDR:0]      wr_ptr;
    logic               flush;
    logic               mem_rd_en;
    logic [ADDR-1:0]    mem_rd_addr;
    logic [WIDTH-1:0]   mem_rd_data;
    logic [ADDR:0]      rd_ptr;
    logic               empty;
    logic               almost_empty;

    fifo_rd_ctrl_if #(.WIDTH(WIDTH)) out_if ();

    fifo_rd_ctrl #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR(ADDR), .AE_THRESH(4)) dut (
        .rd_clk       (rd_clk),
        .rst_n        (rst_n),
        .wr_ptr       (wr_ptr),
        .flush        (flush),
        .mem_rd_en    (mem_rd_en),
        .mem_rd_addr  (mem_rd_addr),
        .mem_rd_data  (mem_rd_data),
        .out_if       (out_if),
        .rd_ptr       (rd_ptr),
        .empty        (empty),
        .almost_empty (almost_empty)
    );

    // ---------------- clock / reset ----------------
    initial begin
        rd_clk = 1'b0;
        forever #5 rd_clk = ~rd_clk;
    end

    // ---------------- memory model ----------------
    logic [WIDTH-1:0] mem [DEPTH];
    initial mem_rd_data = '0;
    always @(posedge rd_clk) begin
        if (mem_rd_en) mem_rd_data <= mem[mem_rd_addr];
    end

    // ---------------- scoreboard ----------------
    logic [WIDTH-1:0] exp_q[$];
    logic [ADDR-1:0]  addr_q[$];
    int n_tests = 0;
    int n_fail  = 0;
    int pop_cnt = 0;
    int rd_cnt  = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    logic             prev_hold = 1'b0;
    logic [WIDTH-1:0] prev_dout = '0;

    // Monitor: compare every pop with the scoreboard, log reads, check hold stability.
    always @(negedge rd_clk) begin
        if (rst_n) begin
            if (prev_hold && !flush) check("dout_stable", out_if.dout, prev_dout);
            if (mem_rd_en) begin
                rd_cnt++;
                addr_q.push_back(mem_rd_addr);
            end
            if (out_if.dout_valid && out_if.dout_ready && !flush) begin
                pop_cnt++;
                if (exp_q.size() == 0) check("pop_unexpected", 1, 0);
                else check("pop_data", out_if.dout, exp_q.pop_front());
            end
            prev_hold = out_if.dout_valid && !out_if.dout_ready && !flush;
            prev_dout = out_if.dout;
        end else begin
            prev_hold = 1'b0;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(posedge rd_clk);
        #1;
    endtask

    // Write n random entries into memory and publish them with one wr_ptr update.
    task automatic push_entries(input int n);
        logic [ADDR:0]  p;
        logic [63:0]    r;
        p = wr_ptr;
        for (int i = 0; i < n; i++) begin
            r = {$urandom(), $urandom()};
            mem[p[ADDR-1:0]] = r[WIDTH-1:0];
            exp_q.push_back(r[WIDTH-1:0]);
            p = p + 1'b1;
        end
        wr_ptr = p;
    endtask

    int base;

    initial begin
        rst_n = 1'b0;
        flush = 1'b0;
        wr_ptr = '0;
        out_if.dout_ready = 1'b0;
        tick(2);

        // Reset state
        check("rst_rd_ptr", rd_ptr, 0);
        check("rst_dout_valid", out_if.dout_valid, 0);
        check("rst_dout", out_if.dout, 0);
        check("rst_mem_rd_en", mem_rd_en, 0);
        check("rst_empty", empty, 1);
        check("rst_almost_empty", almost_empty, AE_ON);
        rst_n = 1'b1;
        tick(1);

        // Single entry latency with consumer stalled
        push_entries(1);
        @(negedge rd_clk);
        check("lat_rd_en", mem_rd_en, 1);
        check("lat_valid_e0", out_if.dout_valid, 0);
        tick(1);
        check("lat_valid_e1", out_if.dout_valid, 0);
        tick(1);
        check("lat_valid_e2", out_if.dout_valid, 1);
        check("lat_dout", out_if.dout, exp_q[0]);
        check("lat_empty", empty, 0);
        check("lat_rd_ptr", rd_ptr, 1);
        out_if.dout_ready = 1'b1;
        tick(2);
        check("lat_drain_empty", empty, 1);
        check("lat_drain_q", exp_q.size(), 0);

        // Backpressure: 8 entries, only 2 reads while stalled, then a full-rate drain
        out_if.dout_ready = 1'b0;
        base = rd_cnt;
        push_entries(8);
        tick(8);
        check("bp_reads", rd_cnt - base, 2);
        check("bp_rd_ptr", rd_ptr, 3);
        check("bp_valid", out_if.dout_valid, 1);
        check("bp_head", out_if.dout, exp_q[0]);
        check("bp_almost_empty", almost_empty, 0);
        base = pop_cnt;
        out_if.dout_ready = 1'b1;
        repeat (8) @(negedge rd_clk);
        @(posedge rd_clk);
        #1;
        check("bp_pops", pop_cnt - base, 8);
        check("bp_empty", empty, 1);

        // Wrap-around via flush to rd_ptr = 1023, then 3 entries
        wr_ptr = 11'd1023;
        flush = 1'b1;
        tick(1);
        flush = 1'b0;
        check("wrap_start_ptr", rd_ptr, 1023);
        check("wrap_start_empty", empty, 1);
        addr_q.delete();
        push_entries(3);
        tick(8);
        check("wrap_nreads", addr_q.size(), 3);
        if (addr_q.size() == 3) begin
            check("wrap_addr0", addr_q[0], 1023);
            check("wrap_addr1", addr_q[1], 0);
            check("wrap_addr2", addr_q[2], 1);
        end
        check("wrap_end_ptr", rd_ptr, 1026);
        check("wrap_bit", rd_ptr[ADDR], 1);
        check("wrap_drained", exp_q.size(), 0);

        // Flush with one entry buffered, one in flight and 5 in memory
        out_if.dout_ready = 1'b0;
        push_entries(1);
        tick(3);
        check("fl1_valid", out_if.dout_valid, 1);
        push_entries(6);
        tick(1);
        flush = 1'b1;
        @(negedge rd_clk);
        check("fl1_no_read", mem_rd_en, 0);
        check("fl1_pre_empty", empty, 0);
        tick(1);
        flush = 1'b0;
        check("fl1_rd_ptr", rd_ptr, wr_ptr);
        check("fl1_valid_low", out_if.dout_valid, 0);
        check("fl1_empty", empty, 1);
        exp_q.delete();

        // Flush with a full buffer and 5 in memory; pop in the flush cycle is ignored
        push_entries(7);
        tick(6);
        check("fl2_valid", out_if.dout_valid, 1);
        flush = 1'b1;
        out_if.dout_ready = 1'b1;
        base = pop_cnt;
        tick(1);
        flush = 1'b0;
        check("fl2_rd_ptr", rd_ptr, wr_ptr);
        check("fl2_valid_low", out_if.dout_valid, 0);
        check("fl2_empty", empty, 1);
        check("fl2_no_pop", pop_cnt - base, 0);
        exp_q.delete();
        push_entries(2);
        tick(6);
        check("fl2_fresh_drained", exp_q.size(), 0);
        check("fl2_fresh_empty", empty, 1);

        // Almost-empty: occupancy 5, then 4 after one pop
        out_if.dout_ready = 1'b0;
        push_entries(5);
        tick(6);
        check("ae_occ5", almost_empty, 0);
        out_if.dout_ready = 1'b1;
        tick(1);
        out_if.dout_ready = 1'b0;
        check("ae_occ4", almost_empty, AE_ON);
        out_if.dout_ready = 1'b1;
        tick(8);
        check("ae_drained", empty, 1);

        // Asynchronous reset in the middle of a burst
        push_entries(20);
        tick(5);
        @(negedge rd_clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_if.dout_valid, 0);
        check("arst_rd_ptr", rd_ptr, 0);
        check("arst_rd_en", mem_rd_en, 0);
        check("arst_dout", out_if.dout, 0);
        base = rd_cnt;
        repeat (3) begin
            @(negedge rd_clk);
            check("arst_hold_rd_en", mem_rd_en, 0);
        end
        check("arst_no_reads", rd_cnt - base, 0);
        wr_ptr = '0;
        exp_q.delete();
        tick(1);
        rst_n = 1'b1;
        tick(1);
        check("arst_empty", empty, 1);

        // Recovery after reset
        push_entries(4);
        tick(8);
        check("rec_drained", exp_q.size(), 0);
        check("rec_empty", empty, 1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
